// File: rtl/baggage_drop_pkg.sv
// Shared types and defaults for the baggage-drop sequencing controller.
// Holds the FSM state encoding, the sensor pair-select encoding and the
// pair-selection rule used by baggage_drop_ctrl.
package baggage_drop_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned FRAC_BITS_DEF  = 4;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        HEIGHT,
        SQRT,
        COMPARE,
        ERROR
    } state_e;

    typedef enum logic [1:0] {
        PAIR_A,
        PAIR_B,
        PAIR_ALL,
        PAIR_NONE
    } pair_e;

    // Pair A is (s1,s3), pair B is (s2,s4); a zero reading marks a sensor faulty.
    function automatic pair_e select_pair(input logic z1, input logic z2,
                                          input logic z3, input logic z4);
        if (z1 || z3) begin
            return (z2 || z4) ? PAIR_NONE : PAIR_B;
        end else if (z2 || z4) begin
            return PAIR_A;
        end else begin
            return PAIR_ALL;
        end
    endfunction

endpackage

// File: rtl/baggage_drop_ctrl_isqrt.sv
// seq_isqrt: restoring bit-serial integer square root.
// load_i starts a new root; one result bit is produced per cycle, MSB first,
// the first bit on the load edge itself, so the root is complete WIDTH edges
// after load and valid_o pulses for one cycle. root_o holds until next load.
module seq_isqrt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [2*WIDTH-1:0] radicand_i,
    output logic               busy_o,
    output logic               valid_o,
    output logic [WIDTH-1:0]   root_o
);

    localparam int unsigned RW = WIDTH + 2;
    localparam int unsigned TW = WIDTH + 4;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [RW-1:0]      rem_q, rem_d, rem_s, rem_n;
    logic [WIDTH-1:0]   root_q, root_d, root_s, root_n;
    logic [2*WIDTH-1:0] rad_q, rad_d, rad_s, rad_n;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d, valid_q, valid_d;
    logic [TW-1:0]      rem_t, trial;

    // One restoring step, applied to freshly loaded operands or the running state
    always_comb begin
        rem_s  = load_i ? '0 : rem_q;
        root_s = load_i ? '0 : root_q;
        rad_s  = load_i ? radicand_i : rad_q;
        rem_t  = {rem_s, rad_s[2*WIDTH-1 -: 2]};
        trial  = {2'b00, root_s, 2'b01};
        rad_n  = {rad_s[2*WIDTH-3:0], 2'b00};
        if (rem_t >= trial) begin
            rem_n  = RW'(rem_t - trial);
            root_n = {root_s[WIDTH-2:0], 1'b1};
        end else begin
            rem_n  = RW'(rem_t);
            root_n = {root_s[WIDTH-2:0], 1'b0};
        end
    end

    // Step sequencing: count WIDTH steps from load, then flag the result
    always_comb begin
        rem_d   = rem_q;
        root_d  = root_q;
        rad_d   = rad_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        if (load_i) begin
            rem_d  = rem_n;
            root_d = root_n;
            rad_d  = rad_n;
            cnt_d  = CW'(1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d  = rem_n;
            root_d = root_n;
            rad_d  = rad_n;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end
        end
    end

    // Engine state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            root_q  <= '0;
            rad_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            root_q  <= root_d;
            rad_q   <= rad_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign root_o  = root_q;

endmodule

// File: rtl/baggage_drop_ctrl.sv
// baggage_drop_ctrl: captures four altitude sensors on request, picks the
// valid sensor pair(s), averages them into a height, takes the fixed-point
// fall time t_act = sqrt(height << 2*FRAC_BITS) on a shared seq_isqrt and
// compares it against t_lim to decide drop_activated.
// Optional build macro: PERIODIC_RUN_EN adds a free-running auto-start every
// PERIOD cycles (auto-starts outside IDLE are dropped).
module baggage_drop_ctrl
    import baggage_drop_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF,
    parameter int unsigned PERIOD     = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   sensor1,
    input  logic [DATA_WIDTH-1:0]   sensor2,
    input  logic [DATA_WIDTH-1:0]   sensor3,
    input  logic [DATA_WIDTH-1:0]   sensor4,
    input  logic [2*DATA_WIDTH-1:0] t_lim,
    input  logic                    drop_en,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [DATA_WIDTH-1:0]   height,
    output logic [DATA_WIDTH-1:0]   t_act,
    output logic                    drop_activated
);

    localparam int unsigned SW   = DATA_WIDTH + 2;
    localparam int unsigned RADW = 2 * DATA_WIDTH;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] s_q [4];
    logic [DATA_WIDTH-1:0] s_d [4];
    logic [RADW-1:0]       tlim_q, tlim_d;
    pair_e                 pair_q, pair_d;
    logic [DATA_WIDTH-1:0] calc_h_q, calc_h_d, h_new;
    logic [DATA_WIDTH-1:0] height_q, height_d, t_act_q, t_act_d;
    logic                  err_q, err_d, drop_q, drop_d, done_q, done_d;
    logic                  sq_load, sq_busy, sq_valid;
    logic [RADW-1:0]       sq_rad;
    logic [DATA_WIDTH-1:0] sq_root;
    logic                  start_eff;

`ifdef PERIODIC_RUN_EN
    localparam int unsigned CNTW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    logic [CNTW-1:0] per_cnt_q, per_cnt_d;
    logic            auto_start;

    // Free-running auto-start counter, wraps after raising auto_start
    always_comb begin
        auto_start = (per_cnt_q == CNTW'(PERIOD - 1));
        per_cnt_d  = auto_start ? '0 : per_cnt_q + CNTW'(1);
    end

    // Auto-start counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) per_cnt_q <= '0;
        else        per_cnt_q <= per_cnt_d;
    end

    assign start_eff = start | auto_start;
`else
    logic unused_period;
    assign unused_period = (PERIOD != 0);
    assign start_eff     = start;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; SQRT falls back to IDLE if the engine stops without a result
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_eff) state_d = SAMPLE;
            SAMPLE:  state_d = HEIGHT;
            HEIGHT:  state_d = (pair_q == PAIR_NONE) ? ERROR : SQRT;
            SQRT: begin
                if (sq_valid)     state_d = COMPARE;
                else if (!sq_busy) state_d = IDLE;
            end
            COMPARE: state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Height from the selected sensors; sums are DATA_WIDTH+2 bits wide
    always_comb begin
        case (pair_q)
            PAIR_A:   h_new = DATA_WIDTH'((SW'(s_q[0]) + SW'(s_q[2]) + SW'(1)) >> 1);
            PAIR_B:   h_new = DATA_WIDTH'((SW'(s_q[1]) + SW'(s_q[3]) + SW'(1)) >> 1);
            PAIR_ALL: h_new = DATA_WIDTH'((SW'(s_q[0]) + SW'(s_q[1]) + SW'(s_q[2])
                                           + SW'(s_q[3]) + SW'(2)) >> 2);
            default:  h_new = '0;
        endcase
    end

    assign sq_rad = RADW'(h_new) << (2 * FRAC_BITS);

    // Per-state datapath and result-register updates
    always_comb begin
        s_d      = s_q;
        tlim_d   = tlim_q;
        pair_d   = pair_q;
        calc_h_d = calc_h_q;
        height_d = height_q;
        t_act_d  = t_act_q;
        err_d    = err_q;
        drop_d   = drop_q;
        done_d   = 1'b0;
        sq_load  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_eff) begin
                    s_d[0] = sensor1;
                    s_d[1] = sensor2;
                    s_d[2] = sensor3;
                    s_d[3] = sensor4;
                    tlim_d = t_lim;
                end
            end
            SAMPLE: begin
                pair_d = select_pair(s_q[0] == '0, s_q[1] == '0,
                                     s_q[2] == '0, s_q[3] == '0);
            end
            HEIGHT: begin
                if (pair_q != PAIR_NONE) begin
                    calc_h_d = h_new;
                    sq_load  = 1'b1;
                end
            end
            COMPARE: begin
                height_d = calc_h_q;
                t_act_d  = sq_root;
                drop_d   = drop_en && ({{DATA_WIDTH{1'b0}}, sq_root} < tlim_q);
                err_d    = 1'b0;
                done_d   = 1'b1;
            end
            ERROR: begin
                err_d  = 1'b1;
                drop_d = 1'b0;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Sample, working and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q      <= '{default: '0};
            tlim_q   <= '0;
            pair_q   <= PAIR_A;
            calc_h_q <= '0;
            height_q <= '0;
            t_act_q  <= '0;
            err_q    <= 1'b0;
            drop_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            s_q      <= s_d;
            tlim_q   <= tlim_d;
            pair_q   <= pair_d;
            calc_h_q <= calc_h_d;
            height_q <= height_d;
            t_act_q  <= t_act_d;
            err_q    <= err_d;
            drop_q   <= drop_d;
            done_q   <= done_d;
        end
    end

    seq_isqrt #(
        .WIDTH(DATA_WIDTH)
    ) u_isqrt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (sq_load),
        .radicand_i(sq_rad),
        .busy_o    (sq_busy),
        .valid_o   (sq_valid),
        .root_o    (sq_root)
    );

    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign err            = err_q;
    assign height         = height_q;
    assign t_act          = t_act_q;
    assign drop_activated = drop_q;

endmodule

// File: tb/tb_baggage_drop_ctrl.sv
// Scoreboard bench for baggage_drop_ctrl: each accepted start pushes the
// expected result (from an arithmetic reference model) and its done cycle;
// a monitor pops and compares whenever done is seen.
module tb_baggage_drop_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned FB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] s1, s2, s3, s4;
    logic [2*DW-1:0] t_lim;
    logic          drop_en;
    logic          busy, done, err, drop_activated;
    logic [DW-1:0] height, t_act;

    baggage_drop_ctrl #(
        .DATA_WIDTH(DW),
        .FRAC_BITS (FB),
        .PERIOD    (1000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .sensor1       (s1),
        .sensor2       (s2),
        .sensor3       (s3),
        .sensor4       (s4),
        .t_lim         (t_lim),
        .drop_en       (drop_en),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .height        (height),
        .t_act         (t_act),
        .drop_activated(drop_activated)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int h;
        int t;
        int e;
        int d;
        int when;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int last_h = 0, last_t = 0, last_d = 0;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Height from the sensor rules; -1 when neither pair is usable
    function automatic int ref_height(input int a, input int b, input int c, input int d);
        bit a_ok = (a != 0) && (c != 0);
        bit b_ok = (b != 0) && (d != 0);
        if (a_ok && b_ok) return (a + b + c + d + 2) / 4;
        if (a_ok)         return (a + c + 1) / 2;
        if (b_ok)         return (b + d + 1) / 2;
        return -1;
    endfunction

    function automatic int ref_sqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic int ref_time(input int h);
        return ref_sqrt(h * (1 << (2 * FB)));
    endfunction

    function automatic logic [DW-1:0] rs();
        if ($urandom_range(0, 4) == 0) return '0;
        return DW'($urandom_range(1, 255));
    endfunction

    // Monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no done", cyc);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("height", int'(height), x.h);
                check("t_act", int'(t_act), x.t);
                check("err", int'(err), x.e);
                check("drop_activated", int'(drop_activated), x.d);
                check("done_cycle", cyc, x.when);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge of the done cycle
    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic [DW-1:0] d,
                         input logic [2*DW-1:0] tl, input logic den);
        exp_t x;
        int h;
        bit ended;
        h = ref_height(int'(a), int'(b), int'(c), int'(d));
        if (h < 0) begin
            x.h = last_h; x.t = last_t; x.e = 1; x.d = 0;
            x.when = cyc + 1 + 3;
        end else begin
            x.h = h; x.t = ref_time(h); x.e = 0;
            x.d = (den && (x.t < int'(tl))) ? 1 : 0;
            x.when = cyc + 1 + 11;
        end
        last_h = x.h; last_t = x.t; last_d = x.d;
        sb.push_back(x);
        s1 = a; s2 = b; s3 = c; s4 = d; t_lim = tl; drop_en = den;
        start = 1'b1;
        ended = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) begin
                start = 1'b0;
                ended = 1'b1;
                break;
            end
            // Junk on the inputs while busy must be ignored
            start = 1'($urandom_range(0, 1));
            s1 = DW'($urandom); s2 = DW'($urandom);
            s3 = DW'($urandom); s4 = DW'($urandom);
            t_lim = (2*DW)'($urandom);
        end
        start = 1'b0;
        check("busy_until_done", ended ? cyc : -1, x.when);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] a, b, c, d;
        logic [2*DW-1:0] tl;
        int h, t;
        rst_n = 1'b0; start = 1'b0; drop_en = 1'b0; t_lim = '0;
        s1 = '0; s2 = '0; s3 = '0; s4 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_height", int'(height), 0);
        check("rst_t_act", int'(t_act), 0);
        check("rst_drop", int'(drop_activated), 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'd100, 8'd100, 8'd100, 8'd100, 16'd161, 1'b1);
        issue(8'd100, 8'd100, 8'd100, 8'd100, 16'd160, 1'b1);
        issue(8'd100, 8'd100, 8'd100, 8'd100, 16'd161, 1'b0);
        drop_en = 1'b1;
        @(negedge clk);
        check("drop_hold", int'(drop_activated), last_d);
        issue(8'd0, 8'd50, 8'd200, 8'd51, 16'd200, 1'b1);
        issue(8'd0, 8'd0, 8'd100, 8'd100, 16'd500, 1'b1);
        issue(8'd100, 8'd100, 8'd100, 8'd100, 16'd161, 1'b1);
        issue(8'd80, 8'd0, 8'd90, 8'd100, 16'd1000, 1'b1);
        issue(8'd255, 8'd255, 8'd255, 8'd255, 16'h1000, 1'b1);

        for (int n = 0; n < 40; n++) begin
            a = rs(); b = rs(); c = rs(); d = rs();
            h = ref_height(int'(a), int'(b), int'(c), int'(d));
            t = (h < 0) ? 0 : ref_time(h);
            case ($urandom_range(0, 3))
                0:       tl = (2*DW)'(t);
                1:       tl = (2*DW)'(t + 1);
                2:       tl = (2*DW)'($urandom_range(0, 65535));
                default: tl = (2*DW)'($urandom_range(0, 300));
            endcase
            issue(a, b, c, d, tl, ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 2) == 0) begin
                drop_en = ~drop_en;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                check("drop_hold", int'(drop_activated), last_d);
            end
        end

        // Abort a run in SQRT with reset
        check("sb_empty_before_reset", sb.size(), 0);
        s1 = 8'd100; s2 = 8'd100; s3 = 8'd100; s4 = 8'd100;
        t_lim = 16'd161; drop_en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_mid_run", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_err", int'(err), 0);
        check("abort_height", int'(height), 0);
        check("abort_t_act", int'(t_act), 0);
        check("abort_drop", int'(drop_activated), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_h = 0; last_t = 0; last_d = 0;
        repeat (15) @(negedge clk);
        check("idle_after_abort", int'(busy), 0);

        issue(8'd0, 8'd100, 8'd0, 8'd100, 16'd300, 1'b1);
        issue(8'd255, 8'd1, 8'd1, 8'd255, 16'd300, 1'b1);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
